// File: rtl/qam16_rx_pkg.sv
// Shared constants for the QAM16 receive frame controller and its byte FIFO.
package qam16_rx_pkg;

  localparam int SYM_W_DEF  = 11;
  localparam int NIB_CAP    = 4;
  localparam int FIFO_DEPTH = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/qam16_byte_fifo.sv
// Two-entry byte FIFO with occupancy count; push and pop may coincide even when full.
module qam16_byte_fifo
  import qam16_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic [1:0] count
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [7:0] mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/qam16_rx_frame_ctrl.sv
// Frame sequencer around an external 1-cycle QAM16 demapper: symbol intake,
// nibble packing into bytes, and a back-pressured byte output stream.
module qam16_rx_frame_ctrl
  import qam16_rx_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [LEN_W-1:0]        frame_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [SYM_W-1:0] s_ar,
  input  logic signed [SYM_W-1:0] s_ai,
  output logic                    dm_valid_i,
  output logic signed [SYM_W-1:0] dm_ar,
  output logic signed [SYM_W-1:0] dm_ai,
  input  logic                    dm_valid_x,
  input  logic [3:0]              dm_x,
  output logic                    m_valid,
  output logic [7:0]              m_data,
  input  logic                    m_ready,
  output logic [1:0]              state
);

  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid holds its payload until then.

  localparam logic [LEN_W:0] ONE_SYM = LEN_W'(1) + (LEN_W+1)'(0);

  logic [LEN_W:0] sym_left;
  logic [1:0]     inflight;
  logic           half;
  logic [3:0]     nib;
  logic           discard;
  logic           done_q;
  logic [1:0]     fifo_count;
  logic [3:0]     occ;
  logic           accept;
  logic           use_x;
  logic           push;
  logic           drained;

  // Occupancy counts every nibble that may still land in the FIFO, so intake
  // stops before a result could find no room.
  assign occ     = {1'b0, fifo_count, 1'b0} + {3'b000, half} + {2'b00, inflight};
  assign s_ready = (state == ST_RUN) && (sym_left != '0) && (occ < 4'(NIB_CAP));
  assign accept  = s_valid && s_ready && !abort;
  assign use_x   = dm_valid_x && !discard && (state != ST_IDLE) && (inflight != 2'd0);
  assign push    = use_x && half && !abort;
  assign drained = (inflight == 2'd0) && !half && (fifo_count == 2'd0);
  assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
  assign done    = done_q || ((state == ST_DRAIN) && drained && !abort);
  assign m_valid = (fifo_count != 2'd0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      sym_left   <= '0;
      inflight   <= 2'd0;
      half       <= 1'b0;
      nib        <= 4'd0;
      discard    <= 1'b0;
      done_q     <= 1'b0;
      dm_valid_i <= 1'b0;
      dm_ar      <= '0;
      dm_ai      <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      sym_left   <= '0;
      inflight   <= 2'd0;
      half       <= 1'b0;
      nib        <= 4'd0;
      discard    <= 1'b1;
      done_q     <= 1'b0;
      dm_valid_i <= 1'b0;
    end else begin
      discard    <= 1'b0;
      done_q     <= (state == ST_IDLE) && start && (frame_len == '0);
      dm_valid_i <= accept;
      if (accept) begin
        dm_ar <= s_ar;
        dm_ai <= s_ai;
      end
      inflight <= inflight + {1'b0, accept} - {1'b0, use_x};
      if (use_x) begin
        if (half) begin
          half <= 1'b0;
        end else begin
          nib  <= dm_x;
          half <= 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start && (frame_len != '0)) begin
            sym_left <= {frame_len, 1'b0};
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sym_left <= sym_left - ONE_SYM;
            if (sym_left == ONE_SYM) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  qam16_byte_fifo u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .flush (abort),
    .push  (push),
    .wdata ({nib, dm_x}),
    .pop   (m_ready),
    .rdata (m_data),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_qam16_rx_frame_ctrl.sv
// Bench for qam16_rx_frame_ctrl: behavioural demapper, random frames, byte scoreboard.
module tb_qam16_rx_frame_ctrl;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         frame_len = 8'd0;
  logic               abort = 1'b0;
  logic               busy, done;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [10:0] s_ar = '0;
  logic signed [10:0] s_ai = '0;
  logic               dm_valid_i;
  logic signed [10:0] dm_ar, dm_ai;
  logic               dm_valid_x;
  logic [3:0]         dm_x;
  logic               m_valid;
  logic [7:0]         m_data;
  logic               m_ready = 1'b0;
  logic [1:0]         state;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_pop_cyc = -1;
  int acc_cnt = 0;
  int rdy_mode = 0;
  bit hung = 0;
  bit pair_odd = 0;
  logic [3:0] first_code;
  bit prev_acc = 0;
  logic signed [10:0] prev_ar, prev_ai;

  qam16_rx_frame_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .frame_len(frame_len), .abort(abort),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready),
    .s_ar(s_ar), .s_ai(s_ai), .dm_valid_i(dm_valid_i), .dm_ar(dm_ar), .dm_ai(dm_ai),
    .dm_valid_x(dm_valid_x), .dm_x(dm_x), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .state(state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // QAM16 code: {I positive, Q positive, |I| outer, |Q| outer}
  function automatic logic [3:0] ref_code(input logic signed [10:0] ar, input logic signed [10:0] ai);
    return {ar > 0, ai > 0, (ar > 4) || (ar < -4), (ai > 4) || (ai < -4)};
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dm_valid_x <= 1'b0;
      dm_x       <= 4'd0;
    end else begin
      dm_valid_x <= dm_valid_i;
      dm_x       <= ref_code(dm_ar, dm_ai);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: byte scoreboard, demapper-feed check, done bookkeeping.
  always @(negedge CLK) begin
    if (RST) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("byte_unexpected", {24'd0, m_data}, 32'hFFFF_FFFF);
        else chk("byte_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        last_pop_cyc = cyc;
      end
      chk("dm_valid_i", {31'd0, dm_valid_i}, {31'd0, prev_acc});
      if (prev_acc && dm_valid_i) begin
        chk("dm_ar", 32'(dm_ar), 32'(prev_ar));
        chk("dm_ai", 32'(dm_ai), 32'(prev_ai));
      end
      prev_acc = s_valid && s_ready && !abort;
      prev_ar  = s_ar;
      prev_ai  = s_ai;
      if (prev_acc) acc_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_acc = 0;
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic signed [10:0] pick();
    case ($urandom_range(0, 3))
      0: return -11'sd6;
      1: return -11'sd2;
      2: return 11'sd2;
      default: return 11'sd6;
    endcase
  endfunction

  task automatic wait_accept();
    int n = 0;
    bit got = 0;
    while (!got && !hung && n < 500) begin
      @(negedge CLK);
      got = s_ready && !abort;
      step();
      n++;
    end
    if (!got && !hung) begin
      hung = 1;
      chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic begin_frame(input int len);
    start = 1'b1;
    frame_len = 8'(len);
    step();
    start = 1'b0;
    pair_odd = 0;
  endtask

  task automatic send_sym(input logic signed [10:0] ar, input logic signed [10:0] ai, input bit model);
    s_valid = 1'b1;
    s_ar = ar;
    s_ai = ai;
    wait_accept();
    s_valid = 1'b0;
    if (!pair_odd) first_code = ref_code(ar, ai);
    else if (model) exp_q.push_back({first_code, ref_code(ar, ai)});
    pair_odd = !pair_odd;
  endtask

  task automatic rand_frame(input int len, input bit b2b);
    begin_frame(len);
    for (int i = 0; i < 2 * len; i++) begin
      if (!b2b) repeat ($urandom_range(0, 2)) step();
      send_sym(pick(), pick(), 1'b1);
    end
  endtask

  task automatic wait_done(input bit chk_lat);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 2000) begin
      step();
      n++;
    end
    chk("done_seen", {31'd0, done_cnt != d0}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("bytes_outstanding", exp_q.size(), 32'd0);
    if (chk_lat) chk("done_latency", done_cyc, last_pop_cyc + 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_dm_valid_i"}, {31'd0, dm_valid_i}, 32'd0);
    chk({tag, "_dm_ar"}, 32'(dm_ar), 32'd0);
    chk({tag, "_dm_ai"}, 32'(dm_ai), 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"}, {24'd0, m_data}, 32'd0);
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
  endtask

  initial begin
    int d0;
    int a0;
    int n;
    repeat (3) step();
    chk_reset_vals("reset");
    RST = 1'b1;
    step();

    // Single byte, directed.
    rdy_mode = 0;
    begin_frame(1);
    send_sym(-11'sd6, -11'sd6, 1'b0);
    send_sym(11'sd6, 11'sd6, 1'b0);
    exp_q.push_back(8'h3F);
    wait_done(1);

    // Two bytes, directed.
    begin_frame(2);
    send_sym(-11'sd2, -11'sd2, 1'b0);
    send_sym(11'sd2, 11'sd2, 1'b0);
    exp_q.push_back(8'h0C);
    send_sym(11'sd6, -11'sd2, 1'b0);
    send_sym(-11'sd6, 11'sd6, 1'b0);
    exp_q.push_back(8'hA7);
    wait_done(1);

    // Back-pressure: intake must stall with two bytes buffered.
    rdy_mode = 1;
    step();
    a0 = acc_cnt;
    fork
      rand_frame(4, 1'b1);
      begin
        repeat (15) @(negedge CLK);
        chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
        chk("bp_accepted", acc_cnt - a0, 32'd4);
        chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
        rdy_mode = 0;
      end
    join
    wait_done(1);

    // Zero-length frame.
    d0 = done_cnt;
    begin_frame(0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_s_ready", {31'd0, s_ready}, 32'd0);
    step();
    chk("zero_done_pulse", {31'd0, done}, 32'd0);
    chk("zero_m_valid", {31'd0, m_valid}, 32'd0);
    chk("zero_done_count", done_cnt - d0, 32'd1);

    // Abort right after the third symbol; nothing from this frame may emerge.
    begin_frame(3);
    for (int i = 0; i < 3; i++) send_sym(pick(), pick(), 1'b0);
    d0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", {30'd0, state}, 32'd0);
    chk("abort_m_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dm_valid_i", {31'd0, dm_valid_i}, 32'd0);
    repeat (5) step();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    rand_frame(1, 1'b1);
    wait_done(1);

    // Asynchronous reset while draining with a byte waiting.
    rdy_mode = 1;
    rand_frame(2, 1'b1);
    n = 0;
    while (!m_valid && n < 50) begin
      step();
      n++;
    end
    chk("drain_state", {30'd0, state}, 32'd2);
    chk("drain_m_valid", {31'd0, m_valid}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    exp_q.delete();
    repeat (2) step();
    RST = 1'b1;
    rdy_mode = 0;
    step();
    rand_frame(2, 1'b0);
    wait_done(1);

    // Random frames with random back-pressure and gaps.
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) begin
      rand_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      wait_done(1);
    end
    rand_frame(25, 1'b0);
    wait_done(1);

    repeat (4) step();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
